// File: rtl/c16_pkg.sv
// c16_pkg: shared constants for the c16 memory path.
// Holds the memory-port owner encoding (also used by the decoder and the
// top-level debug mux) and the default RAM widths.
package c16_pkg;

  localparam int unsigned C16_ADDR_W = 16;
  localparam int unsigned C16_DATA_W = 16;

  typedef logic [1:0] owner_t;

  localparam owner_t OWN_NONE = 2'd0;
  localparam owner_t OWN_CPU  = 2'd1;
  localparam owner_t OWN_DBG  = 2'd2;

  // True when the granted access by this owner returns read data.
  function automatic logic owner_reads(input owner_t owner, input logic we);
    return (owner != OWN_NONE) && !we;
  endfunction

endpackage

// File: rtl/mem_arb_starve.sv
// mem_arb_starve: saturating starvation counter for the debug requester.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   clr          clear the count this cycle (takes priority over inc)
//   inc          count one more denied cycle
//   at_limit     count has reached LIMIT
module mem_arb_starve #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam logic [3:0] LIM = 4'(LIMIT);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIM)) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign at_limit = (cnt == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares RAM port B between CPU load/store micro-ops and
// the debug/loader requester. CPU has fixed priority, except that a debug
// request denied STARVE_LIMIT cycles in a row wins the next cycle.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   cpu_req/we/addr/wdata              CPU access request
//   cpu_gnt, cpu_hold, cpu_rvalid      CPU grant, stall, read-data valid
//   dbg_req/we/addr/wdata              debug access request
//   dbg_gnt, dbg_rvalid                debug grant, read-data valid
//   rdata                              mem_q passed through
//   mem_addr/wdata/we, mem_q           RAM port B
//   dbg_grant_count                    debug grants since reset (wraps)
module mem_port_arbiter
  import c16_pkg::*;
#(
  parameter int unsigned ADDR_W       = C16_ADDR_W,
  parameter int unsigned DATA_W       = C16_DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_hold,
  output logic              cpu_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q,
  output logic [15:0]       dbg_grant_count
);

  owner_t owner;
  owner_t rd_owner_q;
  logic   starve_at_limit;

  // Owner selection; reset forces NONE so nothing reaches the RAM.
  always_comb begin
    owner = OWN_NONE;
    if (!reset) begin
      if (dbg_req && starve_at_limit) begin
        owner = OWN_DBG;
      end else if (cpu_req) begin
        owner = OWN_CPU;
      end else if (dbg_req) begin
        owner = OWN_DBG;
      end
    end
  end

  assign cpu_gnt  = (owner == OWN_CPU);
  assign dbg_gnt  = (owner == OWN_DBG);
  assign cpu_hold = cpu_req && !cpu_gnt && !reset;

  // Port B mux; idle cycles present the CPU address with writes disabled.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    case (owner)
      OWN_CPU: begin
        mem_we = cpu_we;
      end
      OWN_DBG: begin
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        mem_we    = dbg_we;
      end
      default: ;
    endcase
  end

  mem_arb_starve #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .clr      (dbg_gnt || !dbg_req),
    .inc      (dbg_req && !dbg_gnt),
    .at_limit (starve_at_limit)
  );

  // Read tracker: remembers who issued the read for the one-cycle RAM latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_owner_q <= OWN_NONE;
    end else if (owner_reads(owner, mem_we)) begin
      rd_owner_q <= owner;
    end else begin
      rd_owner_q <= OWN_NONE;
    end
  end

  // Gated by reset so a read granted just before reset never reports data.
  assign cpu_rvalid = (rd_owner_q == OWN_CPU) && !reset;
  assign dbg_rvalid = (rd_owner_q == OWN_DBG) && !reset;
  assign rdata      = mem_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_grant_count <= '0;
    end else if (dbg_gnt) begin
      dbg_grant_count <= dbg_grant_count + 16'd1;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single data port (port B) of the dual-port program/data RAM between the CPU load/store micro-ops and a debug/loader requester (switch-driven memory inspector and program loader). Grants one requester per cycle, with fixed CPU priority and a bounded-starvation override for the debug side. Tracks the one-cycle RAM read latency so returned data is flagged to the requester that issued the read. Sits between the decoder's memory signals and ram2 port B in the c16 top level.

## Interface
- ADDR_W, 16, RAM word-address width
- DATA_W, 16, RAM data width
- STARVE_LIMIT, 4, consecutive denied cycles after which a pending debug request wins over the CPU (1..15)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request this cycle
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_gnt  out  1  CPU access issued to RAM this cycle (combinational)
- cpu_hold  out  1  cpu_req denied this cycle; decoder must stall and re-present the request
- cpu_rvalid  out  1  mem_q holds CPU load data (registered)
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug-side equivalents
- dbg_gnt  out  1  debug access issued this cycle
- dbg_rvalid  out  1  mem_q holds debug read data (registered)
- rdata  out  DATA_W  mem_q passed through; qualified by *_rvalid
- mem_addr  out  ADDR_W  to ram2 address_b
- mem_wdata  out  DATA_W  to ram2 data_b
- mem_we  out  1  to ram2 wren_b
- mem_q  in  DATA_W  from ram2 q_b, valid one cycle after address
- dbg_grant_count  out  16  number of debug grants since reset, wraps at 16'hFFFF -> 0

## Operation
- Owner encoding: NONE, CPU, DBG. Chosen combinationally each cycle.
- Priority: DBG when dbg_req && starve_cnt == STARVE_LIMIT; otherwise CPU if cpu_req; otherwise DBG if dbg_req; otherwise NONE.
- Grant: mem_addr/mem_wdata/mem_we driven from the owner's inputs. Under NONE, mem_addr = cpu_addr, mem_wdata = cpu_wdata, mem_we = 0.
- cpu_hold = cpu_req && !cpu_gnt.
- starve_cnt (4 bits):
  - cleared on dbg_gnt or when !dbg_req;
  - otherwise incremented when dbg_req && !dbg_gnt;
  - saturates at STARVE_LIMIT.
- Read tracking: a register captures owner and !we of the granted access. Next cycle it drives cpu_rvalid or dbg_rvalid. Writes never raise rvalid.
- dbg_grant_count increments by 1 on every dbg_gnt.
- During reset, all grants, mem_we and cpu_hold are forced to 0.

## Timing
- Grant and mem_* outputs are combinational from the request (zero latency). The RAM samples them on the same rising edge.
- Read data: *_rvalid is high exactly one cycle after the granting edge, together with valid rdata. Back-to-back reads give rvalid on consecutive cycles.
- Reset values:
  - cpu_rvalid = 0, dbg_rvalid = 0;
  - starve_cnt = 0, dbg_grant_count = 0;
  - cpu_gnt, dbg_gnt, cpu_hold, mem_we = 0 while reset is high.
- Reset while a read is outstanding: the rvalid due on the following cycle is suppressed.
- Both requesting with starve_cnt < STARVE_LIMIT: CPU wins and the counter increments.
- Both requesting at the limit: DBG wins, cpu_hold = 1, and the counter clears next cycle.
- Worst-case debug latency is STARVE_LIMIT+1 cycles. Worst-case CPU hold is 1 cycle per STARVE_LIMIT+1 cycles.
- Write then read of the same address by different owners on consecutive cycles: the read returns the written value (RAM is write-first on port B; the arbiter adds no reordering).

## Structure
- Shared package c16_pkg holds the owner encoding constants (OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_DBG=2'd2) and the default widths. The decoder and the top-level debug mux use the same constants.
- One sub-module is natural: mem_arb_starve, the saturating starvation counter with clear/increment inputs and an at_limit output.
- The owner mux, read tracker and grant counter stay in mem_port_arbiter.

## Test plan
- CPU only: cpu_req=1, we=0, addr=16'h0010, RAM[0x10]=16'hBEEF -> cpu_gnt=1 same cycle; next cycle cpu_rvalid=1, rdata=16'hBEEF, dbg_rvalid=0.
- Contention: both request reads every cycle, STARVE_LIMIT=4 -> CPU granted 4 cycles, DBG on the 5th with cpu_hold=1; pattern repeats; dbg_grant_count=2 after 10 cycles.
- Debug store: dbg_req=1, we=1, addr=16'h0020, wdata=16'h1234, no CPU request -> mem_we=1, no rvalid; a following CPU read of 0x20 returns 16'h1234.
- Starvation clear: dbg_req held 3 cycles against the CPU, then dropped 1 cycle, then re-raised -> counter restarts from 0; DBG is not granted early.
- Reset mid-read: CPU read granted, reset asserted on the next edge -> cpu_rvalid stays 0, counters read 0, mem_we=0 throughout reset.
- Counter wrap: force 65536 debug grants -> dbg_grant_count returns to 16'h0000.
